// File: rtl/psram_pkg.sv
// psram_pkg: shared definitions for the Tang Nano serial PSRAM controller.
//   - SPI opcodes used by the init sequence and by single-byte accesses
//   - controller FSM state encoding
//   - frame geometry: FRAME_BITS, the shifter length-field width, and the
//     width of the shared power-up / gap counter
//   - cmd_frame(): places an 8-bit command at the MSB end of a shifter load word
package psram_pkg;

  localparam int FRAME_BITS = 40;  // opcode(8) + address(24) + data(8)
  localparam int LEN_W      = 6;   // wide enough to hold FRAME_BITS
  localparam int CNT_W      = 16;  // power-up and CE gap counter width

  localparam logic [7:0] OP_RSTEN = 8'h66;
  localparam logic [7:0] OP_RST   = 8'h99;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_RSTEN = 3'd1,
    ST_GAP   = 3'd2,
    ST_RST   = 3'd3,
    ST_GAP2  = 3'd4,
    ST_IDLE  = 3'd5,
    ST_XFER  = 3'd6,
    ST_DONE  = 3'd7
  } psram_state_e;

  // The shifter always transmits from the MSB end, so a short command
  // is left-aligned in the 40-bit load word.
  function automatic logic [FRAME_BITS-1:0] cmd_frame(input logic [7:0] op);
    return {op, {(FRAME_BITS-8){1'b0}}};
  endfunction

endpackage

// File: rtl/psram_spi_shifter.sv
// psram_spi_shifter: 1-bit SPI serialiser for the PSRAM.
// Each bit occupies two sys_clk cycles: phase A (sclk=0, mosi=bit) and
// phase B (sclk=1). miso is sampled on the edge that ends phase B.
// Ports:
//   sys_clk, sys_reset_n  clock, async active-low reset
//   start_i               load load_i/len_i and begin a frame next cycle
//   load_i                frame bits, MSB transmitted first
//   len_i                 number of bits to shift (8 or 40)
//   miso_i                serial data from the PSRAM
//   ce_n_o, sclk_o, mosi_o  PSRAM pins
//   done_o                strobe during the last bit cell's phase B
//                         (the frame ends on this cycle's closing edge)
//   rx_byte_o             last 8 miso bits including the one sampled now;
//                         meaningful together with done_o
module psram_spi_shifter
  import psram_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] load_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  miso_i,
  output logic                  ce_n_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  done_o,
  output logic [7:0]            rx_byte_o
);

  logic                  active_q, active_d;
  logic                  phase_q, phase_d;   // 0 = phase A, 1 = phase B
  logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [7:0]            rx_q, rx_d;

  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    if (start_i) begin
      active_d  = 1'b1;
      phase_d   = 1'b0;
      shift_d   = load_i;
      bit_cnt_d = len_i - LEN_W'(1);
    end else if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        rx_d    = {rx_q[6:0], miso_i};
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt_q == '0) active_d = 1'b0;
        else                 bit_cnt_d = bit_cnt_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
    end
  end

  // phase_q is only ever 1 while active, so it is directly the registered sclk.
  assign sclk_o    = phase_q;
  assign ce_n_o    = ~active_q;
  assign mosi_o    = active_q & shift_q[FRAME_BITS-1];
  assign done_o    = active_q & phase_q & (bit_cnt_q == '0);
  assign rx_byte_o = {rx_q[6:0], miso_i};

endmodule

// File: rtl/psram_arbiter_ctrl.sv
// psram_arbiter_ctrl: two-port single-byte controller for the Tang Nano
// serial PSRAM. Runs power-up wait, Reset Enable (0x66) and Reset (0x99),
// then arbitrates read/write requests and serialises 40-bit frames.
// Macro PSRAM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go
// to the port not granted last (port 0 wins the first tie); otherwise
// port 0 always wins ties.
// Handshake: pN_req_i is a level request whose we/addr/wdata must stay
// stable until pN_ack_i pulses for one cycle; the fields are captured at
// the grant edge and ignored afterwards. A read later pulses pN_rvalid_o
// for one cycle with rdata_o valid in that same cycle; writes have no
// completion pulse.
// Ports:
//   sys_clk, sys_reset_n                 clock, async active-low reset
//   pN_req_i/we_i/addr_i/wdata_i          port N request (N = 0, 1)
//   pN_ack_o, pN_rvalid_o, rdata_o        port N responses, shared rdata
//   init_done_o                          init sequence complete
//   ce_n_o, sclk_o, mosi_o, miso_i       PSRAM pins
//   state_o                              current FSM state (debug)
module psram_arbiter_ctrl
  import psram_pkg::*;
#(
  parameter int PWRUP_CYCLES = 4050,
  parameter int CE_GAP       = 2
) (
  input  logic         sys_clk,
  input  logic         sys_reset_n,
  input  logic         p0_req_i,
  input  logic         p0_we_i,
  input  logic [22:0]  p0_addr_i,
  input  logic [7:0]   p0_wdata_i,
  output logic         p0_ack_o,
  output logic         p0_rvalid_o,
  input  logic         p1_req_i,
  input  logic         p1_we_i,
  input  logic [22:0]  p1_addr_i,
  input  logic [7:0]   p1_wdata_i,
  output logic         p1_ack_o,
  output logic         p1_rvalid_o,
  output logic [7:0]   rdata_o,
  output logic         init_done_o,
  output logic         ce_n_o,
  output logic         sclk_o,
  output logic         mosi_o,
  input  logic         miso_i,
  output psram_state_e state_o
);

  psram_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  init_done_q, init_done_d;
  logic                  port_q, port_d;      // port owning the current frame
  logic                  we_q, we_d;

  logic                  sh_start;
  logic [FRAME_BITS-1:0] sh_load;
  logic [LEN_W-1:0]      sh_len;
  logic                  sh_done;
  logic [7:0]            sh_rx;

  logic                  grant_fire, grant1;
  logic                  sel_we;
  logic [22:0]           sel_addr;
  logic [7:0]            sel_wdata;

  assign grant_fire = (state_q == ST_IDLE) & (p0_req_i | p1_req_i);

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  // last_q = 1 means port 1 was granted last; resetting to 1 hands port 0
  // the first tie.
  logic last_q;
  assign grant1 = p1_req_i & (~p0_req_i | ~last_q);
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n)    last_q <= 1'b1;
    else if (grant_fire) last_q <= grant1;
  end
`else
  assign grant1 = p1_req_i & ~p0_req_i;
`endif

  assign sel_we    = grant1 ? p1_we_i    : p0_we_i;
  assign sel_addr  = grant1 ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = grant1 ? p1_wdata_i : p0_wdata_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    port_d      = port_q;
    we_d        = we_q;
    sh_start    = 1'b0;
    sh_load     = '0;
    sh_len      = LEN_W'(8);
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
          cnt_d    = '0;
          sh_start = 1'b1;
          sh_load  = cmd_frame(OP_RSTEN);
          state_d  = ST_RSTEN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RSTEN: if (sh_done) state_d = ST_GAP;
      ST_GAP: begin
        if (cnt_q == CNT_W'(CE_GAP - 1)) begin
          cnt_d    = '0;
          sh_start = 1'b1;
          sh_load  = cmd_frame(OP_RST);
          state_d  = ST_RST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RST: if (sh_done) state_d = ST_GAP2;
      ST_GAP2: begin
        if (cnt_q == CNT_W'(CE_GAP - 1)) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (grant_fire) begin
          sh_start = 1'b1;
          sh_len   = LEN_W'(FRAME_BITS);
          sh_load  = {(sel_we ? OP_WRITE : OP_READ), 1'b0, sel_addr,
                      (sel_we ? sel_wdata : 8'h00)};
          ack_d    = grant1 ? 2'b10 : 2'b01;
          port_d   = grant1;
          we_d     = sel_we;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        // sh_done marks the final miso sample, so rdata/rvalid land in
        // the first ce_n-high cycle.
        if (sh_done) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d  = sh_rx;
            rvalid_d = port_q ? 2'b10 : 2'b01;
          end
        end
      end
      ST_DONE: begin
        if (cnt_q == CNT_W'(CE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      ack_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= 8'h00;
      init_done_q <= 1'b0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
      port_q      <= port_d;
      we_q        <= we_d;
    end
  end

  psram_spi_shifter u_shifter (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .start_i     (sh_start),
    .load_i      (sh_load),
    .len_i       (sh_len),
    .miso_i      (miso_i),
    .ce_n_o      (ce_n_o),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .done_o      (sh_done),
    .rx_byte_o   (sh_rx)
  );

  assign p0_ack_o    = ack_q[0];
  assign p1_ack_o    = ack_q[1];
  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign rdata_o     = rdata_q;
  assign init_done_o = init_done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_psram_arbiter_ctrl.sv
// tb_psram_arbiter_ctrl: directed bench for psram_arbiter_ctrl with a
// PSRAM pin model (miso driver) and queue-based monitors for frames,
// acks and read completions.
module tb_psram_arbiter_ctrl;
  import psram_pkg::*;

  localparam int PWRUP = 4050;
  localparam int GAP   = 2;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [22:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [7:0]  rdata;
  logic        init_done, ce_n, sclk, mosi;
  logic        miso = 1'b0;
  psram_state_e dbg_state;

  psram_arbiter_ctrl #(.PWRUP_CYCLES(PWRUP), .CE_GAP(GAP)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_ack_o(p0_ack), .p0_rvalid_o(p0_rvalid),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_ack_o(p1_ack), .p1_rvalid_o(p1_rvalid),
    .rdata_o(rdata), .init_done_o(init_done),
    .ce_n_o(ce_n), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso),
    .state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;
  int unsigned cyc = 0;
  int unsigned last_ack_cyc = 0;
  int pin_err = 0;
  bit exp_last = 1'b1;          // expected last-granted port
  logic [7:0] rd_byte = 8'h00;  // byte the PSRAM model returns

  logic [45:0] exp_frame_q[$];  // {len[5:0], frame bits right-aligned}
  logic [0:0]  exp_ack_q[$];    // granted port
  logic [8:0]  exp_rd_q[$];     // {port, rdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s", name);
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // ---------------- PSRAM miso model ----------------
  // Drives the read byte MSB first during bits 32..39; drives 1 during
  // opcode/address bits so any misaligned sampling corrupts rdata.
  initial begin : miso_model
    int mcnt;
    mcnt = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_reset_n || ce_n) begin
        mcnt = 0;
        miso = 1'b0;
      end else if (!sclk) begin
        miso = (mcnt >= 32 && mcnt <= 39) ? rd_byte[39 - mcnt] : 1'b1;
      end else begin
        mcnt++;
      end
    end
  end

  // ---------------- frame monitor ----------------
  initial begin : frame_mon
    logic [39:0] cap;
    logic [45:0] e;
    int cap_bits, low_cyc;
    logic prev_ce_n;
    cap = '0; cap_bits = 0; low_cyc = 0; prev_ce_n = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!sys_reset_n) begin
        cap = '0; cap_bits = 0; low_cyc = 0; prev_ce_n = 1'b1;
      end else begin
        if (ce_n == 1'b0) begin
          low_cyc++;
          if (sclk) begin
            cap = {cap[38:0], mosi};
            cap_bits++;
          end
        end else begin
          if (sclk !== 1'b0 || mosi !== 1'b0) pin_err++;
          if (prev_ce_n == 1'b0) begin
            if (exp_frame_q.size() == 0) begin
              flag("frame_unexpected");
            end else begin
              e = exp_frame_q.pop_front();
              check("frame_bits", cap_bits, e[45:40]);
              check("frame_data", cap, e[39:0]);
              check("frame_ce_low_cycles", low_cyc, 2 * e[45:40]);
            end
            cap = '0; cap_bits = 0; low_cyc = 0;
          end
        end
        prev_ce_n = ce_n;
      end
    end
  end

  // ---------------- ack monitor ----------------
  initial begin : ack_mon
    logic [0:0] e;
    forever begin
      @(negedge sys_clk);
      if (sys_reset_n && (p0_ack || p1_ack)) begin
        if (p0_ack && p1_ack) flag("ack_both_ports");
        else if (exp_ack_q.size() == 0) flag("ack_unexpected");
        else begin
          e = exp_ack_q.pop_front();
          check("ack_port", p1_ack, e);
          check("ack_init_done", init_done, 1);
          check("ack_ce_n", ce_n, 0);
          check("ack_sclk", sclk, 0);
        end
        last_ack_cyc = cyc;
      end
    end
  end

  // ---------------- read completion monitor ----------------
  initial begin : rd_mon
    logic [8:0] e;
    forever begin
      @(negedge sys_clk);
      if (sys_reset_n && (p0_rvalid || p1_rvalid)) begin
        if (p0_rvalid && p1_rvalid) flag("rvalid_both_ports");
        else if (exp_rd_q.size() == 0) flag("rvalid_unexpected");
        else begin
          e = exp_rd_q.pop_front();
          check("rvalid_port", p1_rvalid, e[8]);
          check("rdata", rdata, e[7:0]);
          check("rvalid_latency", cyc - last_ack_cyc, 80);
          check("rvalid_ce_n", ce_n, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [22:0] addr, input logic [7:0] wdata);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  function automatic logic [45:0] frame_of(input bit we, input logic [22:0] addr,
                                           input logic [7:0] wdata);
    return {6'd40, (we ? OP_WRITE : OP_READ), 1'b0, addr, (we ? wdata : 8'h00)};
  endfunction

  task automatic wait_ack(input bit port, input int limit);
    bit got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (port ? p1_ack : p0_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) flag("ack_timeout");
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_frame_q.size() == 0 && exp_ack_q.size() == 0 && exp_rd_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!ok) flag("drain_timeout");
  endtask

  // Pushes expectations, raises the request, drops and scrambles the
  // fields right after the ack so only the latched values can appear.
  task automatic issue(input bit port, input bit we, input logic [22:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rbyte);
    @(negedge sys_clk);
    rd_byte = rbyte;
    exp_frame_q.push_back(frame_of(we, addr, wdata));
    exp_ack_q.push_back(port);
    if (!we) exp_rd_q.push_back({port, rbyte});
    exp_last = port;
    drive_port(port, 1'b1, we, addr, wdata);
    wait_ack(port, 300);
    drive_port(port, 1'b0, ~we, ~addr, ~wdata);
    drain();
  endtask

  task automatic issue_both(input int n);
    int k;
    int unsigned prev;
    bit w;
    @(negedge sys_clk);
    for (int i = 0; i < n; i++) begin
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      w = ~exp_last;
`else
      w = 1'b0;
`endif
      exp_last = w;
      exp_ack_q.push_back(w);
      exp_frame_q.push_back(w ? frame_of(1'b1, 23'h000200, 8'h22)
                              : frame_of(1'b1, 23'h000100, 8'h11));
    end
    drive_port(1'b0, 1'b1, 1'b1, 23'h000100, 8'h11);
    drive_port(1'b1, 1'b1, 1'b1, 23'h000200, 8'h22);
    k = 0;
    prev = 0;
    for (int i = 0; i < n * 100 + 100; i++) begin
      @(negedge sys_clk);
      if (p0_ack || p1_ack) begin
        if (k > 0) check("b2b_period", cyc - prev, 81 + GAP);
        prev = cyc;
        k++;
        if (k == n) break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    if (k != n) flag("b2b_ack_timeout");
    drain();
  endtask

  task automatic wait_ce_high();
    for (int i = 0; i < 60; i++) begin
      if (ce_n) return;
      @(negedge sys_clk);
    end
    flag("ce_high_timeout");
  endtask

  // Releases reset and checks power-up length, the gap between the two
  // init commands, and init_done timing. Caller pushes 0x66/0x99 frames.
  task automatic release_and_check_init();
    int n;
    @(posedge sys_clk);
    #1 sys_reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < PWRUP + 100; i++) begin
      @(negedge sys_clk);
      if (!ce_n) break;
      n++;
    end
    check("pwrup_cycles", n, PWRUP);
    wait_ce_high();
    n = 0;
    while (ce_n && n < 50) begin
      n++;
      @(negedge sys_clk);
    end
    check("init_gap_ge_ce_gap", (n >= GAP), 1);
    check("init_done_mid_init", init_done, 0);
    wait_ce_high();
    n = 0;
    while (!init_done && n < 50) begin
      n++;
      @(negedge sys_clk);
    end
    check("init_done_after_gap2", n, GAP);
    check("init_done_high", init_done, 1);
  endtask

  task automatic push_init_frames();
    exp_frame_q.push_back({6'd8, 32'h0, OP_RSTEN});
    exp_frame_q.push_back({6'd8, 32'h0, OP_RST});
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    repeat (3) @(negedge sys_clk);
    check("rst_ce_n", ce_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_acks", {p1_ack, p0_ack}, 0);
    check("rst_rvalids", {p1_rvalid, p0_rvalid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_state", dbg_state, ST_PWRUP);

    push_init_frames();
    release_and_check_init();

    issue(1'b0, 1'b1, 23'h012345, 8'hA5, 8'h00);
    issue(1'b1, 1'b0, 23'h7FFFFF, 8'h00, 8'h3C);
    check("rdata_holds", rdata, 8'h3C);
    issue(1'b0, 1'b0, 23'h000001, 8'h00, 8'h81);
    issue(1'b1, 1'b1, 23'h400000, 8'h7E, 8'h00);
    issue_both(4);

    // Read aborted by reset around bit 20, with a write request raised
    // during the rerun init that must wait for init_done.
    @(negedge sys_clk);
    rd_byte = 8'hFF;
    exp_ack_q.push_back(1'b1);
    drive_port(1'b1, 1'b1, 1'b0, 23'h155555, 8'h00);
    wait_ack(1'b1, 300);
    drive_port(1'b1, 1'b0, 1'b0, 23'h0, 8'h00);
    repeat (39) @(negedge sys_clk);
    #2 sys_reset_n = 1'b0;
    #1;
    check("midrst_ce_n", ce_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_rvalid", {p1_rvalid, p0_rvalid}, 0);
    check("midrst_state", dbg_state, ST_PWRUP);
    exp_last = 1'b1;
    @(negedge sys_clk);
    push_init_frames();
    exp_frame_q.push_back(frame_of(1'b1, 23'h2AAAAA, 8'h5A));
    exp_ack_q.push_back(1'b0);
    exp_last = 1'b0;
    drive_port(1'b0, 1'b1, 1'b1, 23'h2AAAAA, 8'h5A);
    release_and_check_init();
    wait_ack(1'b0, 100);
    drive_port(1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
    drain();
    repeat (10) @(negedge sys_clk);

    check("frames_left", exp_frame_q.size(), 0);
    check("acks_left", exp_ack_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
    check("idle_pins_quiet", pin_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

endmodule
